// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory unit: FSM state encodings,
// LW/SW opcode constants and the word size in bytes.
package cpu_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with byte-lane write enables and a
// registered read port; contents are never reset.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Lane-masked write and registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we && be[i]) begin
                mem_r[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem_r[index];
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory unit for the CPU Memory stage: valid/ready request, fixed wait
// states, one-cycle response. Optional byte-lane stores with DMEM_BYTEMASK_EN.
module dmem_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTEMASK_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    dmem_state_e state_r, next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        we_r, err_r, ready_r, valid_r;
    logic [31:0] addr_r, wdata_r;
`ifdef DMEM_BYTEMASK_EN
    logic [3:0]  be_r;
`endif

    logic        hs_s, cur_we_s, cur_err_s, arr_we_s;
    logic [31:0] cur_addr_s, cur_wdata_s, arr_rdata_s;
    logic [3:0]  cur_be_s;

    // With zero wait states the array is accessed on the handshake edge itself,
    // so the live request is used in IDLE and the latched copy afterwards
    always_comb begin
        cur_we_s    = we_r;
        cur_addr_s  = addr_r;
        cur_wdata_s = wdata_r;
        if (state_r == DMEM_IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_r;
        end
`ifdef DMEM_BYTEMASK_EN
        cur_be_s = (state_r == DMEM_IDLE) ? req_be : be_r;
`else
        cur_be_s = 4'hF;
`endif
        cur_err_s = (cur_addr_s[1:0] != 2'b00) ||
                    (cur_addr_s[31:AW+2] != {(30-AW){1'b0}});
    end

    // Next-state and wait-counter logic
    always_comb begin
        next_s     = state_r;
        cnt_next_s = cnt_r;
        hs_s       = 1'b0;
        case (state_r)
            DMEM_IDLE: begin
                cnt_next_s = 4'd0;
                if (req_valid) begin
                    hs_s   = 1'b1;
                    next_s = (WAIT_L == 4'd0) ? DMEM_RESP : DMEM_WAIT;
                end else begin
                    next_s = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                cnt_next_s = cnt_r + 4'd1;
                if (cnt_r + 4'd1 == WAIT_L) begin
                    next_s = DMEM_RESP;
                end else begin
                    next_s = DMEM_WAIT;
                end
            end
            DMEM_RESP: begin
                cnt_next_s = 4'd0;
                next_s     = DMEM_IDLE;
            end
            default: begin
                cnt_next_s = 4'd0;
                next_s     = DMEM_IDLE;
            end
        endcase
    end

    // Write only on the edge entering RESP; reset on that edge suppresses it
    assign arr_we_s = reset_n && cur_we_s && !cur_err_s &&
                      (next_s == DMEM_RESP) && (state_r != DMEM_RESP);

    // State, counter, request capture and response strobe registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= DMEM_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= 32'h0;
            wdata_r <= 32'h0;
`ifdef DMEM_BYTEMASK_EN
            be_r    <= 4'h0;
`endif
        end else begin
            state_r <= next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (next_s == DMEM_IDLE);
            valid_r <= (next_s == DMEM_RESP);
            if (hs_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                err_r   <= cur_err_s;
`ifdef DMEM_BYTEMASK_EN
                be_r    <= req_be;
`endif
            end
        end
    end

    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we_s),
        .be   (cur_be_s),
        .index(cur_addr_s[AW+1:2]),
        .wdata(cur_wdata_s),
        .rdata(arr_rdata_s)
    );

    assign req_ready  = ready_r;
    assign resp_valid = valid_r;
    assign resp_err   = valid_r & err_r;
    assign resp_rdata = (valid_r && !err_r && !we_r) ? arr_rdata_s : 32'h0;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed, table-driven bench for dmem_unit: one instance with 2 wait states
// and one with none for the back-to-back sequence.
module tb_dmem_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata;
`ifdef DMEM_BYTEMASK_EN
    logic [3:0]  a_be = 4'hF;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
`ifdef DMEM_BYTEMASK_EN
        .req_be(a_be),
`endif
        .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
    );

    dmem_unit #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
`ifdef DMEM_BYTEMASK_EN
        .req_be(4'hF),
`endif
        .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One request on the 2-wait-state instance; checks latency, ready, strobe and data
    task automatic run_req(input vec_t v, input string name);
        int  lat;
        bit  ready_ok;
        logic        err;
        logic [31:0] rdata;
        @(negedge clk);
        a_valid = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
`ifdef DMEM_BYTEMASK_EN
        a_be = v.be;
`endif
        for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
        @(posedge clk);
        lat = -1; ready_ok = 1'b1; err = 1'b0; rdata = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            a_valid = 1'b0;
            if (a_rvalid) begin
                lat = i; err = a_err; rdata = a_rdata;
                if (a_ready) ready_ok = 1'b0;
                break;
            end
            if (a_ready) ready_ok = 1'b0;
        end
        check({name, " latency"}, 32'(lat), 32'd3);
        check({name, " ready low"}, {31'd0, ready_ok}, 32'd1);
        check({name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
        check({name, " rdata"}, rdata, v.exp_rdata);
        @(negedge clk);
        check({name, " strobe 1cyc"}, {31'd0, a_rvalid}, 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic err, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    initial begin
        int   hs_idx, last_hs, c;
        bit   hs_prev;
        vec_t bq[3];
        bit   seen;

        vecs[0]  = mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
        vecs[2]  = mk(1'b1, 32'h3FC,      32'h12345678, 4'hF, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 32'h3FC,      32'h0,        4'hF, 1'b0, 32'h12345678);
        vecs[4]  = mk(1'b0, 32'h400,      32'h0,        4'hF, 1'b1, 32'h0);
        vecs[5]  = mk(1'b1, 32'h13,       32'hAAAAAAAA, 4'hF, 1'b1, 32'h0);
        vecs[6]  = mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
        vecs[7]  = mk(1'b1, 32'h14,       32'h0BADF00D, 4'hF, 1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 32'h14,       32'h0,        4'hF, 1'b0, 32'h0BADF00D);
        vecs[9]  = mk(1'b0, 32'h12,       32'h0,        4'hF, 1'b1, 32'h0);
        vecs[10] = mk(1'b1, 32'hFFFFFFF0, 32'h55555555, 4'hF, 1'b1, 32'h0);
        vecs[11] = mk(1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
        vecs[12] = mk(1'b0, 32'h3F0,      32'h0,        4'hF, 1'b0, 32'h0);
        vecs[13] = mk(1'b1, 32'h20,       32'h11112222, 4'hF, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 32'h20,       32'h0,        4'hF, 1'b0, 32'h11112222);
        // Location 0x3F0 is written first so its readback is defined
        vecs[12].we = 1'b1; vecs[12].wdata = 32'h0;

        // Reset then idle
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'd0, a_ready}, 32'd1);
        check("reset valid", {31'd0, a_rvalid}, 32'd0);
        check("reset rdata", a_rdata, 32'h0);
        check("reset err", {31'd0, a_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle ready", {31'd0, a_ready}, 32'd1);
        check("idle valid", {31'd0, a_rvalid}, 32'd0);

        for (int i = 0; i < 15; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Reset sampled in WAIT aborts the store and suppresses the response
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        reset_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (a_rvalid) seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (a_rvalid) seen = 1'b1;
        end
        check("abort no resp", {31'd0, seen}, 32'd0);
        run_req(mk(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h11112222), "abort keep");

`ifdef DMEM_BYTEMASK_EN
        run_req(mk(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0), "be full");
        run_req(mk(1'b1, 32'h40, 32'h00000000, 4'h5, 1'b0, 32'h0), "be 0101");
        run_req(mk(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'hFF00FF00), "be merge");
        run_req(mk(1'b1, 32'h40, 32'h12345678, 4'h0, 1'b0, 32'h0), "be none");
        run_req(mk(1'b0, 32'h40, 32'h0, 4'h3, 1'b0, 32'hFF00FF00), "be noop");
`endif

        // Back-to-back on the zero-wait instance with req_valid held high
        bq[0] = mk(1'b1, 32'h8,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        bq[1] = mk(1'b0, 32'h8,    32'h0,        4'hF, 1'b0, 32'hCAFEF00D);
        bq[2] = mk(1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 32'h0);
        @(negedge clk);
        b_valid = 1'b1; b_we = bq[0].we; b_addr = bq[0].addr; b_wdata = bq[0].wdata;
        hs_idx = 0; last_hs = -1; hs_prev = 1'b0; c = 0;
        while (!(hs_idx == 3 && !hs_prev) && c < 30) begin
            if (c > 0) @(negedge clk);
            if (hs_prev) begin
                check($sformatf("b2b%0d valid", hs_idx - 1), {31'd0, b_rvalid}, 32'd1);
                check($sformatf("b2b%0d ready low", hs_idx - 1), {31'd0, b_ready}, 32'd0);
                check($sformatf("b2b%0d err", hs_idx - 1), {31'd0, b_err}, {31'd0, bq[hs_idx-1].exp_err});
                check($sformatf("b2b%0d rdata", hs_idx - 1), b_rdata, bq[hs_idx-1].exp_rdata);
                if (hs_idx == 3) begin
                    b_valid = 1'b0;
                end else begin
                    b_we = bq[hs_idx].we; b_addr = bq[hs_idx].addr; b_wdata = bq[hs_idx].wdata;
                end
                hs_prev = 1'b0;
            end else if (b_ready) begin
                if (last_hs >= 0) check("b2b spacing", 32'(c - last_hs), 32'd2);
                last_hs = c;
                hs_idx++;
                hs_prev = 1'b1;
            end
            c++;
        end
        check("b2b completed", 32'(hs_idx), 32'd3);
        b_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
